// File: rtl/popcount_window_stream.sv
// popcount_window_stream
// Two-stage valid/ready pipeline that classifies each WIDTH-bit word by whether
// its popcount falls inside the window [lo, hi] captured alongside the word.
// Saturating sample and hit counters track consumed results for status readout.

module popcount_window_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int PC_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [PC_W-1:0]  lo,
    input  logic [PC_W-1:0]  hi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [PC_W-1:0]  out_popcnt,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Number of set bits in a word; a plain adder chain is enough for WIDTH <= 32.
    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] word);
        logic [PC_W-1:0] acc;
        acc = {PC_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            acc = acc + PC_W'(word[i]);
        end
        return acc;
    endfunction

    // Stage 1 holds the popcount plus the window bounds captured with the word.
    logic            s1_valid_r;
    logic [PC_W-1:0] s1_pc_r;
    logic [PC_W-1:0] s1_lo_r;
    logic [PC_W-1:0] s1_hi_r;

    // Stage 2 holds the classified result presented on the output.
    logic            s2_valid_r;
    logic            s2_hit_r;
    logic [PC_W-1:0] s2_pc_r;

    logic [CNT_W-1:0] sample_count_r;
    logic [CNT_W-1:0] hit_count_r;

    logic s2_load_s;
    logic s1_load_s;
    logic in_ready_s;
    logic out_fire_s;

    // Handshake and stage-advance decisions; in_ready never looks at in_valid.
    always_comb begin
        s2_load_s  = 1'b0;
        in_ready_s = 1'b0;
        s1_load_s  = 1'b0;
        out_fire_s = 1'b0;
        s2_load_s  = s1_valid_r && (!s2_valid_r || out_ready);
        in_ready_s = !s1_valid_r || s2_load_s;
        s1_load_s  = in_valid && in_ready_s;
        out_fire_s = s2_valid_r && out_ready;
    end

    // Stage 1: capture popcount and window only on an accepted word, so idle
    // (possibly unknown) input data never enters the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_pc_r    <= {PC_W{1'b0}};
            s1_lo_r    <= {PC_W{1'b0}};
            s1_hi_r    <= {PC_W{1'b0}};
        end else if (s1_load_s) begin
            s1_valid_r <= 1'b1;
            s1_pc_r    <= popcount(in_data);
            s1_lo_r    <= lo;
            s1_hi_r    <= hi;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: classify against the captured window; holds while stalled and
    // replaces the old result in the same edge it is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_hit_r   <= 1'b0;
            s2_pc_r    <= {PC_W{1'b0}};
        end else if (s2_load_s) begin
            s2_valid_r <= 1'b1;
            s2_hit_r   <= (s1_pc_r >= s1_lo_r) && (s1_pc_r <= s1_hi_r);
            s2_pc_r    <= s1_pc_r;
        end else if (out_fire_s) begin
            s2_valid_r <= 1'b0;
        end
    end

    // Saturating counters of consumed results and consumed hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_count_r <= {CNT_W{1'b0}};
            hit_count_r    <= {CNT_W{1'b0}};
        end else if (out_fire_s) begin
            if (sample_count_r != CNT_MAX) begin
                sample_count_r <= sample_count_r + CNT_ONE;
            end
            if (s2_hit_r && (hit_count_r != CNT_MAX)) begin
                hit_count_r <= hit_count_r + CNT_ONE;
            end
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = s2_valid_r;
    assign out_hit      = s2_hit_r;
    assign out_popcnt   = s2_pc_r;
    assign sample_count = sample_count_r;
    assign hit_count    = hit_count_r;

endmodule

// File: tb/tb_popcount_window_stream.sv
// Bench for popcount_window_stream: table-driven sweep, hand-written corner
// sequences and a random stream, all checked against a queue-based model.

module tb_popcount_window_stream;

    localparam int W    = 4;
    localparam int CW   = 16;
    localparam int PW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [PW-1:0] lo;
    logic [PW-1:0] hi;
    logic          out_valid;
    logic          out_ready;
    logic          out_hit;
    logic [PW-1:0] out_popcnt;
    logic [CW-1:0] sample_count;
    logic [CW-1:0] hit_count;

    logic          s_in_valid;
    logic          s_in_ready;
    logic [W-1:0]  s_in_data;
    logic [PW-1:0] s_lo;
    logic [PW-1:0] s_hi;
    logic          s_out_valid;
    logic          s_out_ready;
    logic          s_out_hit;
    logic [PW-1:0] s_out_popcnt;
    logic [2:0]    s_sample_count;
    logic [2:0]    s_hit_count;

    always #5 clk = ~clk;

    popcount_window_stream #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lo(lo), .hi(hi),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_popcnt(out_popcnt),
        .sample_count(sample_count), .hit_count(hit_count)
    );

    popcount_window_stream #(.WIDTH(W), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .lo(s_lo), .hi(s_hi),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_hit(s_out_hit), .out_popcnt(s_out_popcnt),
        .sample_count(s_sample_count), .hit_count(s_hit_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of words in flight. A word becomes
    // visible two edges after the cycle it was accepted in, and only once it
    // is at the head of the list. The pipeline holds at most two words.
    typedef struct {
        logic [PW-1:0] pc;
        logic          hit;
        int            rdy;
    } item_t;

    item_t q[$];
    int    edge_cnt = 0;
    int    m_sc = 0;
    int    m_hc = 0;

    // One clock cycle: compare DUT to model before the edge, advance the model
    // with the handshakes of this cycle, then move to the next falling edge.
    task automatic step(output bit acc);
        bit    ov;
        bit    ir;
        item_t it;
        #2;
        ov = (q.size() > 0) && (q[0].rdy <= edge_cnt);
        ir = (q.size() < 2) || out_ready;
        check("in_ready", 32'(in_ready), 32'(ir));
        check("out_valid", 32'(out_valid), 32'(ov));
        if (ov) begin
            check("out_hit", 32'(out_hit), 32'(q[0].hit));
            check("out_popcnt", 32'(out_popcnt), 32'(q[0].pc));
        end
        check("sample_count", 32'(sample_count), 32'(m_sc));
        check("hit_count", 32'(hit_count), 32'(m_hc));
        acc = 1'b0;
        if (rst) begin
            q.delete();
            m_sc = 0;
            m_hc = 0;
        end else begin
            if (ov && out_ready) begin
                it = q.pop_front();
                if (m_sc < MAXC) m_sc++;
                if (it.hit && m_hc < MAXC) m_hc++;
            end
            if (in_valid && ir) begin
                it.pc  = PW'($countones(in_data));
                it.hit = (it.pc >= lo) && (it.pc <= hi);
                it.rdy = edge_cnt + 2;
                q.push_back(it);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
    endtask

    typedef struct {
        logic [W-1:0]  data;
        logic [PW-1:0] lo;
        logic [PW-1:0] hi;
        logic          exp_hit;
        logic [PW-1:0] exp_pc;
    } vec_t;

    vec_t        vecs[16];
    logic [15:0] hit_mask;
    int          pc_tab[16];
    bit          acc;
    int          n_acc;

    initial begin
        // Table for T1: window [2,3] over all 4-bit words.
        hit_mask = 16'h7EE8;
        pc_tab   = '{0, 1, 1, 2, 1, 2, 2, 3, 1, 2, 2, 3, 2, 3, 3, 4};
        for (int i = 0; i < 16; i++) begin
            vecs[i].data    = W'(i);
            vecs[i].lo      = 3'd2;
            vecs[i].hi      = 3'd3;
            vecs[i].exp_hit = hit_mask[i];
            vecs[i].exp_pc  = PW'(pc_tab[i]);
        end

        rst = 1'b1;
        in_valid = 1'b0; in_data = 4'd0; lo = 3'd0; hi = 3'd0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = 4'd0; s_lo = 3'd0; s_hi = 3'd0; s_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_hit", 32'(out_hit), 32'd0);
        check("rst_out_popcnt", 32'(out_popcnt), 32'd0);
        check("rst_sample_count", 32'(sample_count), 32'd0);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // T1: stream all 16 words, one per cycle, no backpressure.
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                in_valid = 1'b1; in_data = vecs[i].data; lo = vecs[i].lo; hi = vecs[i].hi;
            end else begin
                in_valid = 1'b0;
            end
            step(acc);
            if (i >= 1) begin
                check("t1_valid", 32'(out_valid), 32'd1);
                check("t1_hit", 32'(out_hit), 32'(vecs[i-1].exp_hit));
                check("t1_popcnt", 32'(out_popcnt), 32'(vecs[i-1].exp_pc));
            end
        end
        repeat (2) step(acc);
        check("t1_sample_count", 32'(sample_count), 32'd16);
        check("t1_hit_count", 32'(hit_count), 32'd10);

        // T2: five stalled cycles with input always offered.
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = W'($urandom); lo = 3'd1; hi = 3'd2;
            step(acc);
            if (acc) n_acc++;
        end
        check("t2_accepted", 32'(n_acc), 32'd2);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step(acc);

        // T3: window change right after a word does not affect it.
        in_valid = 1'b1; in_data = 4'b0110; lo = 3'd2; hi = 3'd3;
        step(acc);
        lo = 3'd3;
        step(acc);
        check("t3_first_hit", 32'(out_hit), 32'd1);
        in_valid = 1'b0;
        step(acc);
        check("t3_second_hit", 32'(out_hit), 32'd0);
        check("t3_second_valid", 32'(out_valid), 32'd1);
        repeat (2) step(acc);

        // T5: 3-bit counters saturate at 7 (main DUT idles meanwhile).
        for (int i = 0; i < 13; i++) begin
            s_in_valid = (i < 10); s_in_data = 4'hF; s_lo = 3'd0; s_hi = 3'd4;
            step(acc);
        end
        s_in_valid = 1'b0;
        check("t5_sample_sat", 32'(s_sample_count), 32'd7);
        check("t5_hit_sat", 32'(s_hit_count), 32'd7);

        // T4: empty window (lo > hi) after a reset, then an all-inclusive window.
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        lo = 3'd3; hi = 3'd1;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'($urandom); in_data = W'($urandom); out_ready = 1'($urandom);
            step(acc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step(acc);
        check("t4_no_hits", 32'(hit_count), 32'd0);
        lo = 3'd0; hi = 3'd4;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'($urandom); in_data = W'($urandom); out_ready = 1'($urandom);
            step(acc);
            if (out_valid) check("t4_all_hit", 32'(out_hit), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step(acc);

        // T6: reset with two words in flight, then single-word latency.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'b1111; lo = 3'd0; hi = 3'd4;
        repeat (2) step(acc);
        in_valid = 1'b0; rst = 1'b1;
        step(acc);
        rst = 1'b0;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_sample_count", 32'(sample_count), 32'd0);
        check("t6_hit_count", 32'(hit_count), 32'd0);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b0111; lo = 3'd3; hi = 3'd3;
        step(acc);
        in_valid = 1'b0; in_data = 4'bxxxx;
        check("t6_not_yet", 32'(out_valid), 32'd0);
        step(acc);
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_hit", 32'(out_hit), 32'd1);
        check("t6_popcnt", 32'(out_popcnt), 32'd3);
        step(acc);

        // Random stream with random windows and backpressure.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom);
            in_data   = in_valid ? W'($urandom) : 4'bxxxx;
            lo        = PW'($urandom_range(0, 5));
            hi        = PW'($urandom_range(0, 5));
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step(acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
